// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer for the 9-bit lab CPU.
// Owns pc and ir, sequences instruction/data memory handshakes, gates register
// writeback and handles jump/branch, halt and memory timeout.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined;
// otherwise cycle_count/instr_retired are tied to 0.
//
// Handshake: a request (imem_req / dmem_req) is held high for every cycle the
// sequencer sits in the requesting state (FETCH / MEM), with address and write
// enable stable; the matching ack completes the transfer in the cycle it is seen
// high and is ignored in any other state. If no ack arrives within MAX_WAIT
// cycles (MAX_WAIT != 0) the sequencer parks in ERR until reset.
module cpu_sequencer #(
    parameter int PC_W       = 8,
    parameter int START_ADDR = 0,
    parameter int MAX_WAIT   = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [8:0]      imem_rdata,
    output logic [8:0]      ir,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            dec_reg_write,
    input  logic            dec_branch,
    input  logic            dec_jmp,
    input  logic            dec_done,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] target_addr,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            reg_we_en,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            error,
    output logic [15:0]     cycle_count,
    output logic [15:0]     instr_retired,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int              WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [PC_W-1:0]   START_PC  = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]   PC_ONE    = PC_W'(1);

    state_t            state, state_next;
    logic [PC_W-1:0]   pc_next;
    logic              ir_load;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;

    // Timeout fires on the last permitted wait cycle when no ack is present.
    assign timeout   = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
    assign imem_addr = pc;
    assign state_dbg = state;

    // State, pc and ir registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= START_PC;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) ir <= imem_rdata;
        end
    end

    // Wait counter: counts ack-less cycles in FETCH/MEM, zero everywhere else,
    // so it always starts from 0 on entry to a request state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack)) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state, pc update and state-decoded outputs.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we_en  = 1'b0;
        halted     = 1'b0;
        error      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = START_PC;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_DECODE: begin
                state_next = dec_done ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_next = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A read+write decode is treated as a write.
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ack) begin
                    state_next = S_WB;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                reg_we_en  = dec_reg_write;
                state_next = S_FETCH;
                if (dec_jmp) begin
                    pc_next = target_addr;
                end else if (dec_branch && branch_taken) begin
                    pc_next = target_addr;
                end else begin
                    pc_next = pc + PC_ONE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = START_PC;
                end
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic perf_clr;
    logic perf_run;
    logic perf_retire;

    assign perf_clr    = start && (state == S_IDLE || state == S_HALT);
    assign perf_run    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                         (state == S_MEM) || (state == S_WB);
    assign perf_retire = (state == S_WB);

    // Saturating busy-cycle and retired-instruction counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else if (perf_clr) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            if (perf_run && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
            if (perf_retire && instr_retired != 16'hFFFF) instr_retired <= instr_retired + 16'd1;
        end
    end
`else
    assign cycle_count   = '0;
    assign instr_retired = '0;
`endif

endmodule
